// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception unit: register numbers, exception codes,
// Status/Cause bit positions and the redirect FSM state type.
package cp0_pkg;

  localparam logic [4:0] RegCount   = 5'd9;
  localparam logic [4:0] RegCompare = 5'd11;
  localparam logic [4:0] RegStatus  = 5'd12;
  localparam logic [4:0] RegCause   = 5'd13;
  localparam logic [4:0] RegEpc     = 5'd14;

  localparam logic [4:0] ExcInt = 5'd0;
  localparam logic [4:0] ExcRi  = 5'd10;
  localparam logic [4:0] ExcOv  = 5'd12;

  localparam int unsigned StatusIeBit   = 0;
  localparam int unsigned StatusExlBit  = 1;
  localparam int unsigned CauseExcLo    = 2;
  localparam int unsigned CauseIpLo     = 8;
  localparam int unsigned CauseTimerBit = 15;

  typedef enum logic [0:0] {
    StRun,
    StRedirect
  } cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match latches the timer interrupt
// pending bit until software rewrites Compare.
module cp0_timer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            count_we,
  input  logic            compare_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] compare,
  output logic            ip7
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '1;
      ip7     <= 1'b0;
    end else begin
      // A software load replaces this cycle's increment.
      if (count_we) begin
        count <= wdata;
      end else begin
        count <= count + XLEN'(1);
      end
      if (compare_we) begin
        compare <= wdata;
      end
      if (compare_we) begin
        ip7 <= 1'b0;
      end else if (count == compare) begin
        ip7 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt controller: prioritises Ov/RI/ERET/Int, updates Status/Cause/EPC
// and holds a registered PC redirect plus stage flushes until the pipeline takes it.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     NUM_IRQ    = 6,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_ovf_i,
  input  logic [XLEN-1:0]    ex_pc_i,
  input  logic               id_valid_i,
  input  logic               id_ri_i,
  input  logic               id_eret_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               stall_i,
  input  logic               cp0_we_i,
  input  logic [4:0]         cp0_addr_i,
  input  logic [XLEN-1:0]    cp0_wdata_i,
  output logic [XLEN-1:0]    cp0_rdata_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o,
  output logic               flush_if_o,
  output logic               flush_id_o,
  output logic               flush_ex_o,
  output logic [XLEN-1:0]    epc_o,
  output logic               exl_o
);

  logic [NUM_IRQ-1:0] irq_meta;
  logic [NUM_IRQ-1:0] irq_sync;

  logic               ie_q;
  logic               exl_q;
  logic [NUM_IRQ-1:0] im_q;
  logic               im_timer_q;
  logic [4:0]         exc_code_q;
  logic [XLEN-1:0]    epc_q;

  logic [XLEN-1:0]    count;
  logic [XLEN-1:0]    compare;
  logic               ip7;

  cp0_state_e         state_q;
  logic               redirect_q;
  logic [XLEN-1:0]    redirect_pc_q;
  logic               flush_if_q;
  logic               flush_id_q;
  logic               flush_ex_q;

  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign wr_count   = cp0_we_i && (cp0_addr_i == RegCount);
  assign wr_compare = cp0_we_i && (cp0_addr_i == RegCompare);
  assign wr_status  = cp0_we_i && (cp0_addr_i == RegStatus);
  assign wr_cause   = cp0_we_i && (cp0_addr_i == RegCause);
  assign wr_epc     = cp0_we_i && (cp0_addr_i == RegEpc);

  cp0_timer #(
    .XLEN(XLEN)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .count_we  (wr_count),
    .compare_we(wr_compare),
    .wdata     (cp0_wdata_i),
    .count     (count),
    .compare   (compare),
    .ip7       (ip7)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= irq_i;
      irq_sync <= irq_meta;
    end
  end

  logic int_pending;
  logic ev_ov;
  logic ev_ri;
  logic ev_eret;
  logic ev_int;

  assign int_pending = |({ip7, irq_sync} & {im_timer_q, im_q});
  assign ev_ov       = ex_ovf_i;
  assign ev_ri       = id_valid_i & id_ri_i;
  assign ev_eret     = id_valid_i & id_eret_i;
  assign ev_int      = id_valid_i & ie_q & ~exl_q & int_pending;

  logic            take_exc;
  logic            take_eret;
  logic            hw_epc;
  logic [4:0]      sel_code;
  logic [XLEN-1:0] sel_epc;
  logic            sel_flush_ex;

  // Events are only considered in RUN; during REDIRECT the pipeline is being flushed.
  always_comb begin
    take_exc     = 1'b0;
    take_eret    = 1'b0;
    sel_code     = ExcInt;
    sel_epc      = id_pc_i;
    sel_flush_ex = 1'b0;
    if (state_q == StRun) begin
      if (ev_ov) begin
        take_exc     = 1'b1;
        sel_code     = ExcOv;
        sel_epc      = ex_pc_i;
        sel_flush_ex = 1'b1;
      end else if (ev_ri) begin
        take_exc = 1'b1;
        sel_code = ExcRi;
      end else if (ev_eret) begin
        take_eret = 1'b1;
      end else if (ev_int) begin
        take_exc = 1'b1;
      end
    end
  end

  // Nested exceptions (EXL already set) only redirect; EPC/ExcCode keep the first cause.
  assign hw_epc = take_exc & ~exl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      im_timer_q <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      if (take_exc) begin
        exl_q <= 1'b1;
      end else if (take_eret) begin
        exl_q <= 1'b0;
      end else if (wr_status) begin
        ie_q       <= cp0_wdata_i[StatusIeBit];
        exl_q      <= cp0_wdata_i[StatusExlBit];
        im_q       <= cp0_wdata_i[CauseIpLo +: NUM_IRQ];
        im_timer_q <= cp0_wdata_i[CauseTimerBit];
      end
      if (hw_epc) begin
        exc_code_q <= sel_code;
        epc_q      <= sel_epc;
      end else begin
        if (wr_cause) begin
          exc_code_q <= cp0_wdata_i[CauseExcLo +: 5];
        end
        if (wr_epc) begin
          epc_q <= cp0_wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_if_q    <= 1'b0;
      flush_id_q    <= 1'b0;
      flush_ex_q    <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (take_exc || take_eret) begin
            state_q       <= StRedirect;
            redirect_q    <= 1'b1;
            redirect_pc_q <= take_eret ? epc_q : EXC_VECTOR;
            flush_if_q    <= 1'b1;
            flush_id_q    <= take_exc;
            flush_ex_q    <= sel_flush_ex;
          end
        end
        StRedirect: begin
          if (!stall_i) begin
            state_q       <= StRun;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_if_q    <= 1'b0;
            flush_id_q    <= 1'b0;
            flush_ex_q    <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    cp0_rdata_o = '0;
    case (cp0_addr_i)
      RegCount:   cp0_rdata_o = count;
      RegCompare: cp0_rdata_o = compare;
      RegStatus: begin
        cp0_rdata_o[StatusIeBit]           = ie_q;
        cp0_rdata_o[StatusExlBit]          = exl_q;
        cp0_rdata_o[CauseIpLo +: NUM_IRQ]  = im_q;
        cp0_rdata_o[CauseTimerBit]         = im_timer_q;
      end
      RegCause: begin
        cp0_rdata_o[CauseExcLo +: 5]       = exc_code_q;
        cp0_rdata_o[CauseIpLo +: NUM_IRQ]  = irq_sync;
        cp0_rdata_o[CauseTimerBit]         = ip7;
      end
      RegEpc:     cp0_rdata_o = epc_q;
      default:    cp0_rdata_o = '0;
    endcase
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_if_o    = flush_if_q;
  assign flush_id_o    = flush_id_q;
  assign flush_ex_o    = flush_ex_q;
  assign epc_o         = epc_q;
  assign exl_o         = exl_q;

endmodule
